// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_DMA} arb_state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} arb_owner_t;

    localparam logic [31:0] IO_ADDR_DEF = 32'h800;

endpackage

// File: rtl/arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module arb_sat_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] max,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != max)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the data memory / I/O port between the CPU data port and a DMA requester.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter int            MAX_BURST  = 8,
    parameter int            STARVE_LIM = 4,
    parameter logic [AW-1:0] IO_ADDR    = AW'(IO_ADDR_DEF)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    input  logic          dma_last,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    input  logic [7:0]    io_rdata,
    output logic          io_sel,
    output logic          io_we,
    output logic [15:0]   stat_stall,
    output logic [15:0]   stat_beats
);

    localparam int BEAT_W   = $clog2(MAX_BURST + 1);
    localparam int STARVE_W = $clog2(STARVE_LIM + 1);

    localparam logic [BEAT_W-1:0]   BEAT_MAX   = BEAT_W'(MAX_BURST);
    localparam logic [BEAT_W-1:0]   BEAT_LAST  = BEAT_W'(MAX_BURST - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIM);

    arb_state_t          state_q, state_n;
    arb_owner_t          owner;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                beat_clr, beat_inc;
    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;
    logic                gnt_we;
    logic [DW-1:0]       rd_data;

    assign starve_hit = (starve_cnt == STARVE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Grants are gated by reset so an in-flight DMA beat drops the moment reset rises.
    always_comb begin
        state_n  = state_q;
        owner    = OWN_NONE;
        beat_clr = 1'b0;
        beat_inc = 1'b0;
        if (!reset) begin
            case (state_q)
                ARB_IDLE: begin
                    if (dma_req && (starve_hit || !cpu_req)) begin
                        owner = OWN_DMA;
                        if (!dma_last && (MAX_BURST > 1)) begin
                            state_n  = ARB_DMA;
                            beat_inc = 1'b1;
                        end
                    end else if (cpu_req) begin
                        owner = OWN_CPU;
                    end
                end
                ARB_DMA: begin
                    if (dma_req) begin
                        owner = OWN_DMA;
                        if (dma_last || (beat_cnt == BEAT_LAST)) begin
                            state_n  = ARB_IDLE;
                            beat_clr = 1'b1;
                        end else begin
                            beat_inc = 1'b1;
                        end
                    end else begin
                        state_n  = ARB_IDLE;
                        beat_clr = 1'b1;
                    end
                end
                default: begin
                    state_n  = ARB_IDLE;
                    beat_clr = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        gnt_we    = 1'b0;
        case (owner)
            OWN_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                gnt_we    = cpu_we;
            end
            OWN_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                gnt_we    = dma_we;
            end
            default: ;
        endcase
    end

    assign io_sel    = (owner != OWN_NONE) && (mem_addr == IO_ADDR);
    assign mem_we    = gnt_we & ~io_sel;
    assign io_we     = gnt_we & io_sel;
    assign rd_data   = io_sel ? {{(DW-8){1'b0}}, io_rdata} : mem_rdata;
    assign cpu_rdata = (owner == OWN_CPU) ? rd_data : '0;
    assign dma_rdata = (owner == OWN_DMA) ? rd_data : '0;
    assign dma_gnt   = (owner == OWN_DMA);
    assign cpu_stall = cpu_req & ~reset & (owner != OWN_CPU);

    arb_sat_cnt #(.WIDTH(BEAT_W)) u_beat_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (beat_clr),
        .inc   (beat_inc),
        .max   (BEAT_MAX),
        .cnt   (beat_cnt)
    );

    arb_sat_cnt #(.WIDTH(STARVE_W)) u_starve_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (dma_gnt),
        .inc   (dma_req & ~dma_gnt),
        .max   (STARVE_MAX),
        .cnt   (starve_cnt)
    );

`ifdef DMEM_ARB_STATS_EN
    arb_sat_cnt #(.WIDTH(16)) u_stat_stall (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (cpu_stall),
        .max   (16'hFFFF),
        .cnt   (stat_stall)
    );

    arb_sat_cnt #(.WIDTH(16)) u_stat_beats (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (dma_gnt),
        .max   (16'hFFFF),
        .cnt   (stat_beats)
    );
`else
    assign stat_stall = 16'h0;
    assign stat_beats = 16'h0;
`endif

endmodule
